// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and op predicates for the iterative multiply/divide unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one bit of shift-add multiply or restoring divide
module muldiv_step #(
  parameter int Nbits = 64
) (
  input  logic             div,
  input  logic [Nbits-1:0] hi,
  input  logic [Nbits-1:0] lo,
  input  logic [Nbits-1:0] operand,
  output logic [Nbits-1:0] hi_next,
  output logic [Nbits-1:0] lo_next
);

  logic [Nbits:0] sum;
  logic [Nbits:0] rem_sh;
  logic [Nbits:0] diff;

  // hi is the partial product / partial remainder, lo the multiplier / quotient
  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    rem_sh = {hi, lo[Nbits-1]};
    diff   = rem_sh - {1'b0, operand};
    if (div) begin
      hi_next = diff[Nbits] ? rem_sh[Nbits-1:0] : diff[Nbits-1:0];
      lo_next = {lo[Nbits-2:0], ~diff[Nbits]};
    end else begin
      hi_next = sum[Nbits:1];
      lo_next = {sum[0], lo[Nbits-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV M-extension multiply/divide unit with busy/done handshake
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int Nbits = 64,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [Nbits-1:0] a,
  input  logic [Nbits-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [Nbits-1:0] result
);

  localparam int C  = Nbits / BPC;
  localparam int CW = $clog2(C);
  localparam logic [CW-1:0]    LAST    = CW'(C - 1);
  localparam logic [Nbits-1:0] MOST_NEG = {1'b1, {(Nbits-1){1'b0}}};

  state_e           state;
  op_e              op_q;
  logic [Nbits-1:0] hi_q;
  logic [Nbits-1:0] lo_q;
  logic [Nbits-1:0] b_q;
  logic             neg_q;
  logic [CW-1:0]    cnt_q;

  logic [Nbits-1:0] hi_c [0:BPC];
  logic [Nbits-1:0] lo_c [0:BPC];

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar g = 0; g < BPC; g++) begin : g_step
    muldiv_step #(.Nbits(Nbits)) u_step (
      .div     (is_div(op_q)),
      .hi      (hi_c[g]),
      .lo      (lo_c[g]),
      .operand (b_q),
      .hi_next (hi_c[g+1]),
      .lo_next (lo_c[g+1])
    );
  end

  // PREP: lo_q/b_q still hold the raw operands here
  logic             sa, sb, prep_neg, special;
  logic [Nbits-1:0] mag_a, mag_b, special_res;

  always_comb begin
    sa       = is_signed_a(op_q) & lo_q[Nbits-1];
    sb       = is_signed_b(op_q) & b_q[Nbits-1];
    mag_a    = sa ? -lo_q : lo_q;
    mag_b    = sb ? -b_q : b_q;
    prep_neg = (op_q == OP_REM) ? sa : (sa ^ sb);
    special  = 1'b0;
    special_res = '0;
    if (is_div(op_q) && (b_q == '0)) begin
      special     = 1'b1;
      special_res = op_q[1] ? lo_q : '1;
    end else if (((op_q == OP_DIV) || (op_q == OP_REM)) && (lo_q == MOST_NEG) && (b_q == '1)) begin
      special     = 1'b1;
      special_res = op_q[1] ? '0 : lo_q;
    end
  end

  // FIX: hi_q:lo_q is the magnitude product, or remainder:quotient
  logic [2*Nbits-1:0] prod;
  logic [Nbits-1:0]   div_sel, fix_res;

  always_comb begin
    prod    = {hi_q, lo_q};
    if (neg_q) prod = -prod;
    div_sel = op_q[1] ? hi_q : lo_q;
    if (neg_q) div_sel = -div_sel;
    if (is_div(op_q))
      fix_res = div_sel;
    else if (op_q == OP_MUL)
      fix_res = prod[Nbits-1:0];
    else
      fix_res = prod[2*Nbits-1:Nbits];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      op_q   <= OP_MUL;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (kill) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_q  <= op_e'(op);
            lo_q  <= a;
            b_q   <= b;
            hi_q  <= '0;
            state <= S_PREP;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PREP: begin
          if (special) begin
            result <= special_res;
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            lo_q  <= mag_a;
            b_q   <= mag_b;
            hi_q  <= '0;
            neg_q <= prep_neg;
            cnt_q <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          hi_q  <= hi_c[BPC];
          lo_q  <= lo_c[BPC];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_res;
          state  <= S_DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
